fetch_ctrl: RTL and testbench

//  Sequences the IF stage: owns the architectural fetch PC and issues one

---
 rtl/fetch_ctrl_pkg.sv | 29 ++
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and constants for the instruction fetch controller.
//   u32 / u64        : plain unsigned word types for instructions and PCs
//   PC_ALIGN_MASK    : clears the two low PC bits (4-byte instruction grain)
//   PC_STEP          : sequential fetch increment
//   fetch_state_t    : fetch FSM encoding {IDLE, REQ, WAIT, HOLD}
//   align_pc()       : applies PC_ALIGN_MASK to a redirect target
// ----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam u64 PC_STEP       = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    function automatic u64 align_pc(input u64 pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-bus read channel between the fetch controller and memory.
//   ireq_valid     : read request raised by the fetch controller
//   ireq_addr      : read address, stable while ireq_valid is high
//   iresp_addr_ok  : memory accepted the request this cycle
//   iresp_data_ok  : read data valid this cycle
//   iresp_data     : returned instruction word
// Modports: master (fetch controller side), slave (memory side).
// ----------------------------------------------------------------------------
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_addr_ok;
    logic iresp_data_ok;
    u32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// IF-stage sequencer. Owns the architectural fetch PC, issues one
// instruction-bus read at a time and presents {pc, raw_instr, valid} to the
// fetch stage register. Honours downstream stall and redirects; a response
// made stale by a redirect is completed on the bus and then dropped.
//
// Ports
//   clk, reset      : core clock, asynchronous active-high reset
//   stall           : fetch register cannot accept; hold presented output
//   redirect_valid  : restart fetch at redirect_pc (low two bits ignored)
//   redirect_pc     : redirect target
//   ibus            : instruction-bus read channel (fetch_ctrl_if.master)
//   pc_out          : PC of presented instruction
//   raw_instr_out   : presented instruction word
//   valid_out       : pc_out/raw_instr_out meaningful
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetch_cnt  : instructions consumed downstream (wraps)
//   perf_stall_cnt  : cycles spent holding a stalled instruction (wraps)
// ----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 RESET_PC = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  u64           redirect_pc,
    fetch_ctrl_if.master ibus,
    output u64           pc_out,
    output u32           raw_instr_out,
    output logic         valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output u64           perf_fetch_cnt,
    output u64           perf_stall_cnt
`endif
);

    fetch_state_t state, state_nxt;

    u64   pc;
    u64   pend_pc;
    logic pend_redir;
    u32   instr_q;

    u64   redir_pc_al;
    logic data_done;
    logic discard;

    assign redir_pc_al = align_pc(redirect_pc);

    // addr_ok and data_ok together in REQ completes the whole transaction.
    assign data_done = ibus.iresp_data_ok &&
                       ((state == WAIT) || ((state == REQ) && ibus.iresp_addr_ok));

    // A redirect seen earlier or in the completing cycle makes the word stale.
    assign discard = pend_redir || redirect_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (data_done) begin
                    state_nxt = discard ? REQ : HOLD;
                end else if (ibus.iresp_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_done) begin
                    state_nxt = discard ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: all outputs decode registered state, so they only move on clk edges.
    always_comb begin
        ibus.ireq_valid = (state == REQ);
        ibus.ireq_addr  = pc;
        valid_out       = (state == HOLD);
        pc_out          = pc;
        raw_instr_out   = instr_q;
    end

    // PC, pending redirect and captured instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_redir <= 1'b0;
            instr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redir_pc_al;
                    end
                end
                REQ, WAIT: begin
                    if (data_done) begin
                        pend_redir <= 1'b0;
                        if (redirect_valid) begin
                            pc <= redir_pc_al;
                        end else if (pend_redir) begin
                            pc <= pend_pc;
                        end else begin
                            instr_q <= ibus.iresp_data;
                        end
                    end else if (redirect_valid) begin
                        // The bus request cannot be withdrawn; remember the
                        // target and let the outstanding read drain. Last one wins.
                        pend_redir <= 1'b1;
                        pend_pc    <= redir_pc_al;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc <= redir_pc_al;
                    end else if (!stall) begin
                        pc <= pc + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (valid_out && !stall && !redirect_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if ((state == HOLD) && stall) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A bus responder answers reads from a
// synthetic memory; a scoreboard queue holds the {pc, instr} items the fetch
// stage should see, and a monitor compares every presented item against it.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam u64 RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic redirect_valid;
    u64   redirect_pc;
    u64   pc_out;
    u32   raw_instr_out;
    logic valid_out;
`ifdef FETCH_PERF_CNT_EN
    u64   perf_fetch_cnt;
    u64   perf_stall_cnt;
`endif

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus           (bus),
        .pc_out         (pc_out),
        .raw_instr_out  (raw_instr_out),
        .valid_out      (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        u64 pc;
        u32 instr;
    } item_t;

    item_t exp_q[$];
    u64    cur_pc = RST_PC;
    u64    nxt_pc = RST_PC;
    logic  stale = 1'b0;
    int    n_consumed = 0;

    int    addr_lat = 0;
    int    data_lat = 1;
    logic  same_cycle = 1'b0;
    int    ph = 0;
    int    cnt = 0;
    u64    acc_addr = '0;

    function automatic u32 mem_word(input u64 a);
        return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Bus responder: addr_ok after addr_lat waiting cycles, data_ok data_lat
    // cycles after acceptance (or together with addr_ok when same_cycle).
    initial begin
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.iresp_addr_ok = 1'b0;
            bus.iresp_data_ok = 1'b0;
            if (reset) begin
                ph  = 0;
                cnt = 0;
            end else if (ph == 0) begin
                if (bus.ireq_valid) begin
                    if (cnt >= addr_lat) begin
                        n_vec++;
                        if (bus.ireq_addr !== cur_pc) begin
                            n_bad++;
                            $display("FAIL ireq_addr_seq: got %h want %h", bus.ireq_addr, cur_pc);
                        end
                        bus.iresp_addr_ok = 1'b1;
                        acc_addr = bus.ireq_addr;
                        cnt = 0;
                        if (same_cycle) begin
                            bus.iresp_data_ok = 1'b1;
                            bus.iresp_data    = mem_word(acc_addr);
                        end else begin
                            ph = 1;
                        end
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                cnt++;
                if (cnt >= data_lat) begin
                    bus.iresp_data_ok = 1'b1;
                    bus.iresp_data    = mem_word(acc_addr);
                    ph  = 0;
                    cnt = 0;
                end
            end
        end
    end

    // Monitor and reference model, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (valid_out) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL out_unexpected: pc_out %h raw %h, nothing expected", pc_out, raw_instr_out);
                    end else if (pc_out !== exp_q[0].pc || raw_instr_out !== exp_q[0].instr) begin
                        n_bad++;
                        $display("FAIL out_item: got pc %h instr %h want pc %h instr %h",
                                 pc_out, raw_instr_out, exp_q[0].pc, exp_q[0].instr);
                    end
                    if ((!stall || redirect_valid) && exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                    end
                    if (!stall && !redirect_valid) begin
                        cur_pc = cur_pc + 64'd4;
                        n_consumed++;
                    end
                end
                if (redirect_valid) begin
                    if (valid_out) begin
                        cur_pc = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
                    end else begin
                        nxt_pc = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
                        stale  = 1'b1;
                    end
                end
                if (bus.iresp_data_ok) begin
                    if (stale) begin
                        cur_pc = nxt_pc;
                        stale  = 1'b0;
                    end else begin
                        exp_q.push_back(item_t'{pc: cur_pc, instr: mem_word(cur_pc)});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        exp_q.delete();
        cur_pc     = RST_PC;
        nxt_pc     = RST_PC;
        stale      = 1'b0;
        n_consumed = 0;
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!valid_out && t < 200) begin
            @(posedge clk); #2; t++;
        end
        ok = valid_out;
    endtask

    task automatic wait_ph1(output bit ok);
        int t = 0;
        while (ph != 1 && t < 200) begin
            @(posedge clk); #2; t++;
        end
        ok = (ph == 1);
    endtask

    task automatic wait_ireq(output bit ok);
        int t = 0;
        while (!bus.ireq_valid && t < 200) begin
            @(posedge clk); #2; t++;
        end
        ok = bus.ireq_valid;
    endtask

    task automatic wait_consumed(input int target, output bit ok);
        int t = 0;
        while (n_consumed < target && t < 500) begin
            @(posedge clk); #2; t++;
        end
        ok = (n_consumed >= target);
    endtask

    task automatic test_reset();
        int lat;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        addr_lat       = 0;
        data_lat       = 1;
        same_cycle     = 1'b0;
        #2;
        n_vec++;
        if (valid_out !== 1'b0 || bus.ireq_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valids: valid_out %b ireq_valid %b want 0 0", valid_out, bus.ireq_valid);
        end
        n_vec++;
        if (bus.ireq_addr !== RST_PC || pc_out !== RST_PC || raw_instr_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_values: ireq_addr %h pc_out %h raw %h want %h %h 0",
                     bus.ireq_addr, pc_out, raw_instr_out, RST_PC, RST_PC);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #2; lat++;
        end
        n_vec++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL first_latency: got %0d cycles want 3", lat);
        end
    endtask

    task automatic test_stream();
        bit ok;
        wait_consumed(6, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL stream_progress: consumed %0d want >= 6", n_consumed);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        addr_lat = 2;
        data_lat = 2;
        base = n_consumed;
        wait_consumed(base + 4, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL slow_bus_progress: consumed %0d want >= %0d", n_consumed, base + 4);
        end
        addr_lat = 0;
        data_lat = 1;
    endtask

    task automatic test_stall();
        bit ok;
        u64 hold_pc;
        u32 hold_instr;
`ifdef FETCH_PERF_CNT_EN
        u64 stall_base;
`endif
        wait_valid(ok);
        stall = 1'b1;
        hold_pc    = pc_out;
        hold_instr = raw_instr_out;
`ifdef FETCH_PERF_CNT_EN
        stall_base = perf_stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            n_vec++;
            if (!ok || valid_out !== 1'b1 || pc_out !== hold_pc || raw_instr_out !== hold_instr ||
                bus.ireq_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_freeze: valid %b pc %h raw %h ireq %b want 1 %h %h 0",
                         valid_out, pc_out, raw_instr_out, bus.ireq_valid, hold_pc, hold_instr);
            end
        end
        stall = 1'b0;
        @(posedge clk); #2;
        n_vec++;
        if (valid_out !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== hold_pc + 64'd4) begin
            n_bad++;
            $display("FAIL stall_release: valid %b ireq %b addr %h want 0 1 %h",
                     valid_out, bus.ireq_valid, bus.ireq_addr, hold_pc + 64'd4);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_stall_cnt - stall_base !== 64'd5) begin
            n_bad++;
            $display("FAIL perf_stall: delta %0d want 5", perf_stall_cnt - stall_base);
        end
`endif
    endtask

    task automatic test_redirect_wait();
        bit ok;
        data_lat = 3;
        wait_ph1(ok);
        @(posedge clk); #2;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_ireq(ok);
        n_vec++;
        if (!ok || bus.ireq_addr !== 64'h8000_0100) begin
            n_bad++;
            $display("FAIL redirect_wait: ireq %b addr %h want 1 80000100", bus.ireq_valid, bus.ireq_addr);
        end
        data_lat = 1;
        wait_consumed(n_consumed + 2, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL redirect_wait_resume: no progress, consumed %0d", n_consumed);
        end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        wait_valid(ok);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0203;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        n_vec++;
        if (!ok || valid_out !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0200) begin
            n_bad++;
            $display("FAIL redirect_hold: valid %b ireq %b addr %h want 0 1 80000200",
                     valid_out, bus.ireq_valid, bus.ireq_addr);
        end
        wait_consumed(n_consumed + 2, ok);
    endtask

    task automatic test_double_redirect();
        bit ok;
        data_lat = 4;
        wait_ph1(ok);
        @(posedge clk); #2;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        @(posedge clk); #2;
        redirect_pc    = 64'h8000_0200;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_ireq(ok);
        n_vec++;
        if (!ok || bus.ireq_addr !== 64'h8000_0200) begin
            n_bad++;
            $display("FAIL double_redirect: ireq %b addr %h want 1 80000200", bus.ireq_valid, bus.ireq_addr);
        end
        data_lat = 1;
        wait_consumed(n_consumed + 2, ok);
    endtask

    task automatic test_same_cycle();
        bit ok;
        int base;
        same_cycle = 1'b1;
        base = n_consumed;
        wait_consumed(base + 3, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL same_cycle_progress: consumed %0d want >= %0d", n_consumed, base + 3);
        end
        same_cycle = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        wait_valid(ok);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_valid(ok);
        @(posedge clk); #2;
        n_vec++;
        if (!ok || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h0) begin
            n_bad++;
            $display("FAIL pc_wrap: ireq %b addr %h want 1 0", bus.ireq_valid, bus.ireq_addr);
        end
        wait_consumed(n_consumed + 1, ok);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        data_lat = 5;
        wait_ph1(ok);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (valid_out !== 1'b0 || bus.ireq_valid !== 1'b0 || bus.ireq_addr !== RST_PC ||
            pc_out !== RST_PC || raw_instr_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_wait: valid %b ireq %b addr %h pc %h raw %h",
                     valid_out, bus.ireq_valid, bus.ireq_addr, pc_out, raw_instr_out);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetch_cnt !== 64'h0 || perf_stall_cnt !== 64'h0) begin
            n_bad++;
            $display("FAIL perf_reset: fetch %0d stall %0d want 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        model_clear();
        data_lat = 1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        wait_ireq(ok);
        n_vec++;
        if (!ok || bus.ireq_addr !== RST_PC) begin
            n_bad++;
            $display("FAIL refetch_reset_pc: ireq %b addr %h want 1 %h", bus.ireq_valid, bus.ireq_addr, RST_PC);
        end
        wait_consumed(3, ok);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL post_reset_progress: consumed %0d want >= 3", n_consumed);
        end
`ifdef FETCH_PERF_CNT_EN
        n_vec++;
        if (perf_fetch_cnt !== 64'(n_consumed)) begin
            n_bad++;
            $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, n_consumed);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_double_redirect();
        test_same_cycle();
        test_wrap();
        test_reset_mid_wait();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
